// File: rtl/apb_req_master_pkg.sv
// rtl/apb_req_master_pkg.sv - shared state encoding and parameter defaults for apb_req_master
package apb_req_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int ADDR_W_DEFAULT  = 32;
  localparam int DATA_W_DEFAULT  = 32;
  localparam int TIMEOUT_DEFAULT = 255;

  // psel is asserted for the whole SETUP+ACCESS window
  function automatic logic on_bus(state_e s);
    return (s == ST_SETUP) || (s == ST_ACCESS);
  endfunction

endpackage

// File: rtl/apb_req_master_if.sv
// rtl/apb_req_master_if.sv - request/response streams plus APB bus seen by apb_req_master
interface apb_req_master_if
  import apb_req_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) ();
  localparam int STRB_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              resp_tmo;

  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic              psel;
  logic              penable;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb, resp_ready,
           pready, pslverr, prdata,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_tmo,
           paddr, pwrite, pwdata, pstrb, psel, penable
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb, resp_ready,
           pready, pslverr, prdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_tmo,
           paddr, pwrite, pwdata, pstrb, psel, penable
  );

endinterface

// File: rtl/apb_tmo_cnt.sv
// rtl/apb_tmo_cnt.sv - saturating watchdog counter; hit marks the LIMIT-th enabled cycle
module apb_tmo_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] LAST = W'((LIMIT > 0) ? LIMIT - 1 : 0);
  localparam logic [W-1:0] MAX  = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts cycles already waited, so the current one is the LIMIT-th at LIMIT-1
  assign hit = en && (LIMIT != 0) && (cnt_q >= LAST);

endmodule

// File: rtl/apb_req_master.sv
// rtl/apb_req_master.sv - APB initiator turning a request stream into SETUP/ACCESS transfers
module apb_req_master
  import apb_req_master_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic              pclk,
  input logic              presetn,
  apb_req_master_if.master bus
);
  localparam int STRB_W = DATA_W / 8;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              resp_tmo_q, resp_tmo_d;

  logic accept;
  logic cnt_en;
  logic tmo_hit;

  assign accept = req_ready_q && bus.req_valid;
  assign cnt_en = (state_q == ST_ACCESS) && !bus.pready;

  apb_tmo_cnt #(
    .LIMIT (TIMEOUT)
  ) u_tmo_cnt (
    .clk   (pclk),
    .rst_n (presetn),
    .clr   (accept),
    .en    (cnt_en),
    .hit   (tmo_hit)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      resp_tmo_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      resp_tmo_q   <= resp_tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (bus.pready || tmo_hit) state_d = ST_RESP;
      ST_RESP:   if (bus.resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Bus controls are decoded from the next state so they only move on FSM edges
  always_comb begin
    req_ready_d  = (state_d == ST_IDLE);
    psel_d       = on_bus(state_d);
    penable_d    = (state_d == ST_ACCESS);
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    resp_tmo_d   = resp_tmo_q;

    if (accept) begin
      paddr_d  = bus.req_addr;
      pwrite_d = bus.req_write;
      pwdata_d = bus.req_wdata;
      pstrb_d  = bus.req_write ? bus.req_wstrb : '0;
    end

    if (state_q == ST_ACCESS) begin
      if (bus.pready) begin
        resp_valid_d = 1'b1;
        resp_rdata_d = pwrite_q ? '0 : bus.prdata;
        resp_err_d   = bus.pslverr;
        resp_tmo_d   = 1'b0;
      end else if (tmo_hit) begin
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_err_d   = 1'b1;
        resp_tmo_d   = 1'b1;
      end
    end

    if ((state_q == ST_RESP) && bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.pstrb      = pstrb_q;
  assign bus.psel       = psel_q;
  assign bus.penable    = penable_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_tmo   = resp_tmo_q;

endmodule
